bcd_key_entry: RTL and testbench

- Operator-input counterpart of the 7-segment display path: the board drives the display, and this block lets the operator type a decimal number back into the design.
- Samples a 4-bit slide-switch digit and three active-low push keys (push, clear, enter).
- Debounces the keys and assembles up to 6 decimal digits.
- Maintains the binary equivalent incrementally and presents a display-ready BCD image, using 4'hF for empty positions (shown as "-").
- Sits between the board I/O and the processor data-input/load path.

---
 rtl/bcd_key_entry.sv | 150 +++++++++++++++
 tb/tb_bcd_key_entry.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_key_entry.sv
`default_nettype none
// ============================================================================
// Module  : bcd_key_entry
// Brief   : Debounced keypad entry of up to NDIG decimal digits -> binary + BCD
// Revision: 1.0
// ============================================================================
module bcd_key_entry #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int NDIG            = 6
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            sw_digit,
  input  logic                  key_push_n,
  input  logic                  key_clr_n,
  input  logic                  key_enter_n,
  output logic [19:0]           value,
  output logic [4*NDIG-1:0]     bcd,
  output logic [2:0]            ndigits,
  output logic                  valid,
  output logic                  err
);

  localparam int                  c_cnt_w   = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [c_cnt_w-1:0]  c_cnt_max = c_cnt_w'(DEBOUNCE_CYCLES - 1);
  localparam logic [2:0]          c_ndig    = 3'(NDIG);
  localparam logic [4*NDIG-5:0]   c_fill    = '1;

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ENTRY = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t       r_state;
  logic [3:0]   r_sw_s1;
  logic [3:0]   r_sw_s2;
  logic [2:0]   w_keys_n;
  logic [2:0]   w_press;
  logic         w_push;
  logic         w_clr;
  logic         w_enter;
  logic         w_digit_ok;
  logic         w_room;
  logic [19:0]  w_value_x10;
  logic [4*NDIG-1:0] w_bcd_first;
  logic [4*NDIG-1:0] w_bcd_shift;

  assign w_keys_n = {key_enter_n, key_clr_n, key_push_n};

  // Per key: synchronizer, stability counter and a registered press pulse
  for (genvar k = 0; k < 3; k++) begin : g_key
    logic               r_s1;
    logic               r_s2;
    logic               r_db;
    logic               r_evt;
    logic [c_cnt_w-1:0] r_cnt;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_s1  <= 1'b1;
        r_s2  <= 1'b1;
        r_db  <= 1'b1;
        r_evt <= 1'b0;
        r_cnt <= '0;
      end else begin
        r_s1  <= w_keys_n[k];
        r_s2  <= r_s1;
        r_evt <= 1'b0;
        if (r_s2 == r_db) begin
          r_cnt <= '0;
        end else if (r_cnt == c_cnt_max) begin
          r_cnt <= '0;
          r_db  <= r_s2;
          r_evt <= ~r_s2;
        end else begin
          r_cnt <= r_cnt + c_cnt_w'(1);
        end
      end
    end

    assign w_press[k] = r_evt;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sw_s1 <= 4'd0;
      r_sw_s2 <= 4'd0;
    end else begin
      r_sw_s1 <= sw_digit;
      r_sw_s2 <= r_sw_s1;
    end
  end

  // Priority clr > enter > push
  assign w_clr   = w_press[1];
  assign w_enter = w_press[2] & ~w_clr;
  assign w_push  = w_press[0] & ~w_clr & ~w_press[2];

  assign w_digit_ok  = (r_sw_s2 <= 4'd9);
  assign w_room      = (ndigits < c_ndig);
  assign w_value_x10 = (value << 3) + (value << 1) + {16'd0, r_sw_s2};
  assign w_bcd_first = {c_fill, r_sw_s2};
  assign w_bcd_shift = {bcd[4*NDIG-5:0], r_sw_s2};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EMPTY;
      value   <= 20'd0;
      bcd     <= '1;
      ndigits <= 3'd0;
      valid   <= 1'b0;
      err     <= 1'b0;
    end else begin
      valid <= 1'b0;
      err   <= 1'b0;
      if (w_clr) begin
        r_state <= S_EMPTY;
        value   <= 20'd0;
        bcd     <= '1;
        ndigits <= 3'd0;
      end else if (w_enter) begin
        // EMPTY always holds value 0, so the pulse needs no special case
        valid <= 1'b1;
        if (r_state == S_ENTRY) begin
          r_state <= S_HOLD;
        end
      end else if (w_push) begin
        if (!w_digit_ok) begin
          err <= 1'b1;
        end else if (r_state == S_ENTRY) begin
          if (w_room) begin
            value   <= w_value_x10;
            bcd     <= w_bcd_shift;
            ndigits <= ndigits + 3'd1;
          end else begin
            err <= 1'b1;
          end
        end else begin
          r_state <= S_ENTRY;
          value   <= {16'd0, r_sw_s2};
          bcd     <= w_bcd_first;
          ndigits <= 3'd1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_bcd_key_entry.sv
`default_nettype none
// ============================================================================
// Module  : tb_bcd_key_entry
// Brief   : Randomized scoreboard bench for bcd_key_entry against a digit-list model
// Revision: 1.0
// ============================================================================
module tb_bcd_key_entry;

  localparam int DB   = 4;
  localparam int NDIG = 6;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [3:0]  sw_digit = 4'd0;
  logic        key_push_n = 1'b1;
  logic        key_clr_n = 1'b1;
  logic        key_enter_n = 1'b1;
  logic [19:0] value;
  logic [23:0] bcd;
  logic [2:0]  ndigits;
  logic        valid;
  logic        err;

  bcd_key_entry #(.DEBOUNCE_CYCLES(DB), .NDIG(NDIG)) dut (
    .clk(clk), .rst(rst), .sw_digit(sw_digit),
    .key_push_n(key_push_n), .key_clr_n(key_clr_n), .key_enter_n(key_enter_n),
    .value(value), .bcd(bcd), .ndigits(ndigits), .valid(valid), .err(err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    bit          is_err;
    logic [19:0] val;
  } exp_t;
  exp_t exp_q[$];

  // Reference model: the list of entered digits plus a "committed" flag
  int m_dig[$];
  bit m_hold = 1'b0;

  function automatic logic [19:0] m_value();
    int v;
    v = 0;
    foreach (m_dig[i]) v = v * 10 + m_dig[i];
    return 20'(v);
  endfunction

  function automatic logic [23:0] m_bcd();
    logic [23:0] b;
    int n;
    b = '1;
    n = m_dig.size();
    for (int i = 0; i < n; i++) b[4*i +: 4] = 4'(m_dig[n-1-i]);
    return b;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic check_state(input string name);
    check({name, " value"}, 32'(value), 32'(m_value()));
    check({name, " bcd"}, 32'(bcd), 32'(m_bcd()));
    check({name, " ndigits"}, 32'(ndigits), 32'(m_dig.size()));
  endtask

  task automatic model_push(input int d);
    exp_t e;
    if (d > 9) begin
      e.is_err = 1'b1; e.val = m_value(); exp_q.push_back(e);
    end else if (m_hold || m_dig.size() == 0) begin
      m_dig.delete();
      m_dig.push_back(d);
      m_hold = 1'b0;
    end else if (m_dig.size() == NDIG) begin
      e.is_err = 1'b1; e.val = m_value(); exp_q.push_back(e);
    end else begin
      m_dig.push_back(d);
    end
  endtask

  task automatic model_enter();
    exp_t e;
    e.is_err = 1'b0; e.val = m_value(); exp_q.push_back(e);
    if (m_dig.size() > 0) m_hold = 1'b1;
  endtask

  task automatic model_clr();
    m_dig.delete();
    m_hold = 1'b0;
  endtask

  // Hold the selected keys low for hold_cyc cycles, then let them settle released
  task automatic act(input bit p, input bit c, input bit e, input int hold_cyc);
    @(negedge clk);
    key_push_n  = ~p;
    key_clr_n   = ~c;
    key_enter_n = ~e;
    repeat (hold_cyc) @(negedge clk);
    key_push_n  = 1'b1;
    key_clr_n   = 1'b1;
    key_enter_n = 1'b1;
    repeat (12) @(negedge clk);
  endtask

  task automatic do_push(input int d);
    sw_digit = 4'(d);
    model_push(d);
    act(1'b1, 1'b0, 1'b0, 10);
    check_state($sformatf("push %0d", d));
  endtask

  task automatic do_enter();
    model_enter();
    act(1'b0, 1'b0, 1'b1, 10);
    check_state("enter");
  endtask

  task automatic do_clr();
    model_clr();
    act(1'b0, 1'b1, 1'b0, 10);
    check_state("clr");
  endtask

  // Monitor: every valid/err pulse must match the oldest expected response
  always @(negedge clk) begin
    exp_t e;
    if (rst && (valid || err)) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL unexpected pulse: got valid=%0b err=%0b value=%0h expected no pulse",
                 valid, err, value);
      end else begin
        e = exp_q.pop_front();
        if (valid !== ~e.is_err || err !== e.is_err || value !== e.val) begin
          n_errors++;
          $display("FAIL pulse: got valid=%0b err=%0b value=%0h expected valid=%0b err=%0b value=%0h",
                   valid, err, value, ~e.is_err, e.is_err, e.val);
        end
      end
    end
  end

  initial begin
    int r;
    repeat (3) @(negedge clk);
    check("reset value", 32'(value), 32'd0);
    check("reset bcd", 32'(bcd), 32'hFFFFFF);
    check("reset ndigits", 32'(ndigits), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset err", 32'(err), 32'd0);
    rst = 1'b1;
    repeat (3) @(negedge clk);

    do_enter();
    do_push(1); do_push(2); do_push(3);
    check("value 123", 32'(value), 32'h7B);
    check("bcd 123", 32'(bcd), 32'hFFF123);
    do_enter();
    do_enter();
    do_push(5);
    check("fresh from hold", 32'(bcd), 32'hFFFFF5);

    do_clr();
    repeat (7) do_push(9);
    check("value 999999", 32'(value), 32'hF423F);
    check("bcd 999999", 32'(bcd), 32'h999999);
    do_push(10);

    do_clr();
    sw_digit = 4'd3;
    act(1'b1, 1'b0, 1'b0, 2);
    check_state("glitch");
    model_push(3);
    act(1'b1, 1'b0, 1'b0, 20);
    check_state("long hold");

    do_clr();
    do_push(1); do_push(2); do_push(3); do_enter();
    do_push(15);
    do_push(5);
    check("hold push 5", 32'(value), 32'd5);
    model_clr();
    act(1'b0, 1'b1, 1'b1, 10);
    check_state("clr+enter");
    do_enter();

    for (int i = 0; i < 60; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 5) do_push($urandom_range(0, 11));
      else if (r <= 7) do_enter();
      else if (r == 8) do_clr();
      else begin
        sw_digit = 4'($urandom_range(0, 9));
        act(1'b1, 1'b0, 1'b0, $urandom_range(1, 3));
        check_state("random glitch");
      end
    end

    do_clr();
    do_push(4); do_push(2);
    check("value 42", 32'(value), 32'd42);
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("async rst value", 32'(value), 32'd0);
    check("async rst bcd", 32'(bcd), 32'hFFFFFF);
    check("async rst ndigits", 32'(ndigits), 32'd0);
    check("async rst valid", 32'(valid), 32'd0);
    model_clr();
    exp_q.delete();

    sw_digit   = 4'd7;
    key_push_n = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("held key early", 32'(ndigits), 32'd0);
    model_push(7);
    repeat (10) @(negedge clk);
    key_push_n = 1'b1;
    repeat (12) @(negedge clk);
    check_state("held through reset");

    check("pending pulses", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
